mha_qkv_sram_sched: RTL and testbench

//  Burst scheduler and arbiter for the 48-lane QKV buffer SRAM (3 QKV segments x 16 channel lanes) in the MHA block.

---
 rtl/mha_qkv_sram_sched_if.sv | 63 ++++++
 rtl/mha_qkv_sram_sched.sv | 224 ++++++++++++++++++++++
 tb/tb_mha_qkv_sram_sched.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mha_qkv_sram_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : mha_qkv_sram_sched_if
// Description : Bundle of requester handshakes and SRAM-side signals for the
//               QKV buffer burst scheduler.
//               master : requester / SRAM side. Drives wr_*/rd_* requests and
//                        receives grants, SRAM controls and read-data tags.
//               slave  : the scheduler itself.
//               With MHA_SRAM_SCHED_PERF_EN defined, the bundle also carries
//               stall_cnt[31:0].
// Revision    : 1.0 - initial release
// ============================================================================
interface mha_qkv_sram_sched_if #(
    parameter int AW    = 8,
    parameter int SAW   = 6,
    parameter int LEN_W = 4
);
    // Writer (PE array) handshake
    logic             wr_req;
    logic [SAW-1:0]   wr_base;
    logic [LEN_W-1:0] wr_len;
    logic             wr_gnt;
    logic             wr_done;
    // Reader (attention engine) handshake
    logic             rd_req;
    logic [SAW-1:0]   rd_base;
    logic [LEN_W-1:0] rd_len;
    logic             rd_gnt;
    logic             rd_done;
    // SRAM controls, 48 packed lane addresses per port
    logic             sram_we;
    logic             sram_rd_en;
    logic [48*AW-1:0] sram_waddr;
    logic [48*AW-1:0] sram_raddr;
    // Read-data tags and status
    logic             rd_dvalid;
    logic             rd_dlast;
    logic             busy;
`ifdef MHA_SRAM_SCHED_PERF_EN
    logic [31:0]      stall_cnt;
`endif

    modport master (
        output wr_req, wr_base, wr_len, rd_req, rd_base, rd_len,
        input  wr_gnt, wr_done, rd_gnt, rd_done,
        input  sram_we, sram_rd_en, sram_waddr, sram_raddr,
        input  rd_dvalid, rd_dlast, busy
`ifdef MHA_SRAM_SCHED_PERF_EN
        , input stall_cnt
`endif
    );

    modport slave (
        input  wr_req, wr_base, wr_len, rd_req, rd_base, rd_len,
        output wr_gnt, wr_done, rd_gnt, rd_done,
        output sram_we, sram_rd_en, sram_waddr, sram_raddr,
        output rd_dvalid, rd_dlast, busy
`ifdef MHA_SRAM_SCHED_PERF_EN
        , output stall_cnt
`endif
    );
endinterface
`default_nettype wire

// File: rtl/mha_qkv_sram_sched.sv
`default_nettype none
// ============================================================================
// Module      : mha_qkv_sram_sched
// Description : Burst scheduler / round-robin arbiter for the 48-lane QKV
//               buffer SRAM (3 segments x 16 channel lanes). Grants one whole
//               burst at a time to the PE-array writer or the attention
//               reader, generates per-lane wrapped addresses, and tags the
//               returned read data with valid/last.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - mha_qkv_sram_sched_if.slave (requests, grants,
//                        SRAM we/rd_en/addresses, rd_dvalid/rd_dlast, busy)
// Config      : MHA_SRAM_SCHED_PERF_EN - adds the saturating stall_cnt
//               counter on the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module mha_qkv_sram_sched #(
    parameter int ROW_COUNT = 192,
    parameter int SEG_ROWS  = 64,
    parameter int AW        = $clog2(ROW_COUNT),
    parameter int SAW       = $clog2(SEG_ROWS),
    parameter int LEN_W     = 4
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    mha_qkv_sram_sched_if.slave bus
);

    localparam int NSEG  = 3;
    localparam int NCH   = 16;
    localparam int NLANE = NSEG * NCH;

    localparam logic [AW-1:0]    C_SEG  = AW'(SEG_ROWS);
    localparam logic [AW-1:0]    C_STEP = AW'(NCH);
    localparam logic [LEN_W-1:0] C_ONE  = LEN_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_t;

    state_t               state_q;
    logic                 last_rd_q;    // 1: reader owned the last burst
    logic [AW-1:0]        row_q;        // segment-relative row of current beat
    logic [LEN_W-1:0]     rem_q;        // beats still to issue after this one
    logic                 wr_gnt_q, wr_done_q, rd_gnt_q, rd_done_q;
    logic                 we_q, rd_en_q, dvalid_q, dlast_q, busy_q;
    logic [NLANE*AW-1:0]  waddr_q, raddr_q;

    logic                 w_pick_wr, w_pick_rd;
    logic [AW-1:0]        row_d;
    logic [NLANE*AW-1:0]  w_lane_addr;

    // Operands are always below 2*SEG_ROWS, so one conditional subtract
    // implements the modulo without a divider.
    function automatic logic [AW-1:0] seg_wrap(input logic [AW-1:0] v);
        return (v >= C_SEG) ? (v - C_SEG) : v;
    endfunction

    // Round robin: on a tie the requester that did not own the last burst wins.
    always_comb begin
        w_pick_wr = bus.wr_req && (!bus.rd_req || last_rd_q);
        w_pick_rd = bus.rd_req && !w_pick_wr;
    end

    // Row of the beat about to be issued: reduced base at grant, otherwise
    // the current row advanced by one 16-row stride, wrapping in the segment.
    always_comb begin
        row_d = seg_wrap(row_q + C_STEP);
        if (state_q == S_IDLE) begin
            if (w_pick_wr) begin
                row_d = seg_wrap({{(AW-SAW){1'b0}}, bus.wr_base});
            end else begin
                row_d = seg_wrap({{(AW-SAW){1'b0}}, bus.rd_base});
            end
        end
    end

    // Lane i = q*16+ch addresses q*SEG_ROWS + ((row + ch) mod SEG_ROWS).
    for (genvar q = 0; q < NSEG; q++) begin : g_seg
        for (genvar ch = 0; ch < NCH; ch++) begin : g_lane
            assign w_lane_addr[(q*NCH+ch)*AW +: AW] =
                AW'(q * SEG_ROWS) + seg_wrap(row_d + AW'(ch));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            last_rd_q <= 1'b1;
            row_q     <= '0;
            rem_q     <= '0;
            wr_gnt_q  <= 1'b0;
            wr_done_q <= 1'b0;
            rd_gnt_q  <= 1'b0;
            rd_done_q <= 1'b0;
            we_q      <= 1'b0;
            rd_en_q   <= 1'b0;
            waddr_q   <= '0;
            raddr_q   <= '0;
            dvalid_q  <= 1'b0;
            dlast_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            wr_gnt_q  <= 1'b0;
            wr_done_q <= 1'b0;
            rd_gnt_q  <= 1'b0;
            rd_done_q <= 1'b0;
            we_q      <= 1'b0;
            rd_en_q   <= 1'b0;
            waddr_q   <= '0;
            raddr_q   <= '0;
            // SRAM read latency is one cycle.
            dvalid_q  <= rd_en_q;
            dlast_q   <= rd_done_q;
            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (w_pick_wr) begin
                        state_q   <= S_WR;
                        busy_q    <= 1'b1;
                        last_rd_q <= 1'b0;
                        wr_gnt_q  <= 1'b1;
                        row_q     <= row_d;
                        if (bus.wr_len == '0) begin
                            // Empty burst: grant and done together, no beat.
                            wr_done_q <= 1'b1;
                            rem_q     <= '0;
                        end else begin
                            we_q      <= 1'b1;
                            waddr_q   <= w_lane_addr;
                            wr_done_q <= (bus.wr_len == C_ONE);
                            rem_q     <= bus.wr_len - C_ONE;
                        end
                    end else if (w_pick_rd) begin
                        state_q   <= S_RD;
                        busy_q    <= 1'b1;
                        last_rd_q <= 1'b1;
                        rd_gnt_q  <= 1'b1;
                        row_q     <= row_d;
                        if (bus.rd_len == '0) begin
                            rd_done_q <= 1'b1;
                            rem_q     <= '0;
                        end else begin
                            rd_en_q   <= 1'b1;
                            raddr_q   <= w_lane_addr;
                            rd_done_q <= (bus.rd_len == C_ONE);
                            rem_q     <= bus.rd_len - C_ONE;
                        end
                    end
                end
                S_WR: begin
                    if (rem_q == '0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        rem_q     <= rem_q - C_ONE;
                        row_q     <= row_d;
                        we_q      <= 1'b1;
                        waddr_q   <= w_lane_addr;
                        wr_done_q <= (rem_q == C_ONE);
                    end
                end
                S_RD: begin
                    if (rem_q == '0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        rem_q     <= rem_q - C_ONE;
                        row_q     <= row_d;
                        rd_en_q   <= 1'b1;
                        raddr_q   <= w_lane_addr;
                        rd_done_q <= (rem_q == C_ONE);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wr_gnt     = wr_gnt_q;
    assign bus.wr_done    = wr_done_q;
    assign bus.rd_gnt     = rd_gnt_q;
    assign bus.rd_done    = rd_done_q;
    assign bus.sram_we    = we_q;
    assign bus.sram_rd_en = rd_en_q;
    assign bus.sram_waddr = waddr_q;
    assign bus.sram_raddr = raddr_q;
    assign bus.rd_dvalid  = dvalid_q;
    assign bus.rd_dlast   = dlast_q;
    assign bus.busy       = busy_q;

`ifdef MHA_SRAM_SCHED_PERF_EN
    logic [31:0] stall_q;
    logic        w_wr_wait, w_rd_wait;

    // A request is being served while its own burst runs or on the IDLE
    // cycle it wins arbitration; any other cycle with req high is a stall.
    always_comb begin
        w_wr_wait = bus.wr_req && !((state_q == S_WR) ||
                                    ((state_q == S_IDLE) && w_pick_wr));
        w_rd_wait = bus.rd_req && !((state_q == S_RD) ||
                                    ((state_q == S_IDLE) && w_pick_rd));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if ((w_wr_wait || w_rd_wait) && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign bus.stall_cnt = stall_q;
`else
    // Stall counting is compiled out; the bus carries no stall_cnt.
`endif

endmodule
`default_nettype wire

// File: tb/tb_mha_qkv_sram_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mha_qkv_sram_sched
// Description : Directed self-checking bench for mha_qkv_sram_sched. Inputs
//               are driven on the falling edge, outputs sampled on the next
//               falling edge. Expected values are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mha_qkv_sram_sched;

    localparam int AW    = 8;
    localparam int SAW   = 6;
    localparam int LEN_W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mha_qkv_sram_sched_if #(.AW(AW), .SAW(SAW), .LEN_W(LEN_W)) bus ();

    mha_qkv_sram_sched #(
        .ROW_COUNT (192),
        .SEG_ROWS  (64),
        .AW        (AW),
        .SAW       (SAW),
        .LEN_W     (LEN_W)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic logic [AW-1:0] lane(input logic [48*AW-1:0] v, input int i);
        return v[i*AW +: AW];
    endfunction

    function automatic logic any_out();
        return |{bus.wr_gnt, bus.wr_done, bus.rd_gnt, bus.rd_done,
                 bus.sram_we, bus.sram_rd_en, bus.sram_waddr, bus.sram_raddr,
                 bus.rd_dvalid, bus.rd_dlast, bus.busy};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic got;
        bus.wr_req  = 1'b0;
        bus.wr_base = '0;
        bus.wr_len  = '0;
        bus.rd_req  = 1'b0;
        bus.rd_base = '0;
        bus.rd_len  = '0;

        // ---- Reset state
        repeat (3) @(negedge clk);
        chk("rst_outs", any_out(), 0);
`ifdef MHA_SRAM_SCHED_PERF_EN
        chk("rst_stall", bus.stall_cnt, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);

        // ---- Write burst, base 0, len 4: lane 19 (q=1,ch=3)
        bus.wr_base = 6'd0;
        bus.wr_len  = 4'd4;
        bus.wr_req  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("wr_we",      bus.sram_we, 1);
            chk("wr_rden",    bus.sram_rd_en, 0);
            chk("wr_gnt",     bus.wr_gnt, (k == 0));
            chk("wr_done",    bus.wr_done, (k == 3));
            chk("wr_lane19",  lane(bus.sram_waddr, 19), 67 + 16*k);
            chk("wr_raddr0",  bus.sram_raddr, 0);
            chk("wr_busy",    bus.busy, 1);
        end
        bus.wr_req = 1'b0;
        @(negedge clk);
        chk("wr_end_we",    bus.sram_we, 0);
        chk("wr_end_busy",  bus.busy, 0);
        chk("wr_end_waddr", bus.sram_waddr, 0);

        // ---- Read burst with wrap, base 60, len 2
        bus.rd_base = 6'd60;
        bus.rd_len  = 4'd2;
        bus.rd_req  = 1'b1;
        @(negedge clk);
        chk("rd0_en",     bus.sram_rd_en, 1);
        chk("rd0_gnt",    bus.rd_gnt, 1);
        chk("rd0_lane5",  lane(bus.sram_raddr, 5), 1);
        chk("rd0_lane32", lane(bus.sram_raddr, 32), 188);
        chk("rd0_dvalid", bus.rd_dvalid, 0);
        chk("rd0_waddr0", bus.sram_waddr, 0);
        @(negedge clk);
        chk("rd1_en",     bus.sram_rd_en, 1);
        chk("rd1_done",   bus.rd_done, 1);
        chk("rd1_lane5",  lane(bus.sram_raddr, 5), 17);
        chk("rd1_lane32", lane(bus.sram_raddr, 32), 140);
        chk("rd1_dvalid", bus.rd_dvalid, 1);
        chk("rd1_dlast",  bus.rd_dlast, 0);
        bus.rd_req = 1'b0;
        @(negedge clk);
        chk("rd2_en",     bus.sram_rd_en, 0);
        chk("rd2_dvalid", bus.rd_dvalid, 1);
        chk("rd2_dlast",  bus.rd_dlast, 1);
        @(negedge clk);
        chk("rd3_dvalid", bus.rd_dvalid, 0);
        chk("rd3_dlast",  bus.rd_dlast, 0);

        // ---- Zero-length write
        bus.wr_len = 4'd0;
        bus.wr_req = 1'b1;
        @(negedge clk);
        chk("z_gnt",  bus.wr_gnt, 1);
        chk("z_done", bus.wr_done, 1);
        chk("z_we",   bus.sram_we, 0);
        bus.wr_req = 1'b0;
        @(negedge clk);
        chk("z_we2",  bus.sram_we, 0);
        chk("z_busy", bus.busy, 0);

        // ---- Reset asserted in the middle of a read burst
        bus.rd_base = 6'd0;
        bus.rd_len  = 4'd8;
        bus.rd_req  = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rden", bus.sram_rd_en, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", any_out(), 0);
        bus.rd_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rel_busy", bus.busy, 0);
        chk("mid_rel_outs", any_out(), 0);

        // ---- Tie after reset: WR, IDLE, RD, IDLE, then WR again
        do_reset();
        bus.wr_base = 6'd0;
        bus.rd_base = 6'd0;
        bus.wr_len  = 4'd1;
        bus.rd_len  = 4'd1;
        bus.wr_req  = 1'b1;
        bus.rd_req  = 1'b1;
        @(negedge clk);
        chk("tie_wr_gnt",  bus.wr_gnt, 1);
        chk("tie_rd_gnt0", bus.rd_gnt, 0);
        chk("tie_wr_done", bus.wr_done, 1);
        bus.wr_req = 1'b0;
        @(negedge clk);
        chk("tie_idle1",   bus.busy, 0);
        chk("tie_idle1_g", bus.rd_gnt, 0);
        @(negedge clk);
        chk("tie_rd_gnt",  bus.rd_gnt, 1);
        chk("tie_rd_done", bus.rd_done, 1);
        chk("tie_wr_gnt0", bus.wr_gnt, 0);
        bus.wr_req = 1'b1;
        @(negedge clk);
        chk("tie_idle2",   bus.busy, 0);
        @(negedge clk);
        chk("tie2_wr_gnt", bus.wr_gnt, 1);
        chk("tie2_rd_gnt", bus.rd_gnt, 0);
        bus.wr_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("tie3_rd_gnt", bus.rd_gnt, 1);
        bus.rd_req = 1'b0;
        @(negedge clk);

`ifdef MHA_SRAM_SCHED_PERF_EN
        // ---- Reader waits behind a 3-beat write
        do_reset();
        bus.wr_len = 4'd3;
        bus.rd_len = 4'd1;
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (bus.wr_done) bus.wr_req = 1'b0;
            if (bus.rd_gnt) begin
                got = 1'b1;
                chk("stall_cnt", bus.stall_cnt, 4);
                bus.rd_req = 1'b0;
            end
        end
        chk("perf_rd_gnt_seen", got, 1);
`else
        got = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
